// File: rtl/reg_file_bank_pkg.sv
// rtl/reg_file_bank_pkg.sv - shared definitions for the register bank
// Contents:
//   clr_state_e   clear-sweep FSM state encoding (ST_IDLE, ST_CLEAR)
//   DEF_DATA_W    default entry width in bits
//   DEF_DEPTH     default entry count
package reg_file_bank_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// rtl/reg_file_clear_fsm.sv - clear sweep sequencer for reg_file_bank
// Walks every entry index once, issuing one zero-write per cycle.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   clear_req      start a sweep (ignored while a sweep runs)
//   clear_busy     sweep in progress
//   clr_we         zero-write strobe for this cycle
//   clr_addr       entry index being zeroed this cycle
module reg_file_clear_fsm
  import reg_file_bank_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] counter_q, counter_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          counter_d = '0;
        end
      end
      ST_CLEAR: begin
        // Counter wraps to 0 after LAST, so it is already 0 back in IDLE.
        counter_d = counter_q + AW'(1);
        if (counter_q == LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        counter_d = '0;
      end
    endcase
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign clr_we     = clear_busy;
  assign clr_addr   = counter_q;

endmodule

// File: rtl/reg_file_bank.sv
// rtl/reg_file_bank.sv - parametrised byte-masked register bank with clear sweep
// Optional feature macro: REG_FILE_BYPASS_EN (write-to-read forwarding).
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   wr_valid / wr_ready    write handshake; wr_ready low during a clear sweep
//   wr_addr, wr_data       write index and data
//   wr_be                  byte enables, bit i covers wr_data[8i+7:8i]
//   rd_addr_a, rd_addr_b   read indices
//   rd_data_a, rd_data_b   registered read data (1-cycle latency)
//   clear_req              start clear sweep
//   clear_busy             clear sweep in progress
//   all_regs               flat view, entry k at [k*DATA_W +: DATA_W]
module reg_file_bank
  import reg_file_bank_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int AW     = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [BE_W-1:0]         wr_be,
  input  logic [AW-1:0]           rd_addr_a,
  input  logic [AW-1:0]           rd_addr_b,
  output logic [DATA_W-1:0]       rd_data_a,
  output logic [DATA_W-1:0]       rd_data_b,
  input  logic                    clear_req,
  output logic                    clear_busy,
  output logic [DEPTH*DATA_W-1:0] all_regs
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_next_a, rd_next_b;
  logic              wr_fire;
  logic              clr_we;
  logic [AW-1:0]     clr_addr;

  reg_file_clear_fsm #(
    .DEPTH(DEPTH)
  ) u_clear_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // Ready depends only on FSM state, so writers see no comb path from inputs.
  assign wr_ready = !clear_busy;
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    merged = mem_q[wr_addr];
    for (int b = 0; b < BE_W; b++) begin
      if (wr_be[b]) begin
        merged[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // Clear writes and accepted writes never coincide (wr_ready is low during
  // the sweep), so the priority order below is only a tidy default.
  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        mem_q[k] <= '0;
      end else if (clr_we && (clr_addr == AW'(k))) begin
        mem_q[k] <= '0;
      end else if (wr_fire && (wr_addr == AW'(k))) begin
        mem_q[k] <= merged;
      end
    end
    assign all_regs[k*DATA_W +: DATA_W] = mem_q[k];
  end

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    rd_next_a = mem_q[rd_addr_a];
    if (clr_we && (clr_addr == rd_addr_a)) begin
      rd_next_a = '0;
    end else if (wr_fire && (wr_addr == rd_addr_a)) begin
      rd_next_a = merged;
    end
  end

  always_comb begin
    rd_next_b = mem_q[rd_addr_b];
    if (clr_we && (clr_addr == rd_addr_b)) begin
      rd_next_b = '0;
    end else if (wr_fire && (wr_addr == rd_addr_b)) begin
      rd_next_b = merged;
    end
  end
`else
  assign rd_next_a = mem_q[rd_addr_a];
  assign rd_next_b = mem_q[rd_addr_b];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= rd_next_a;
      rd_data_b <= rd_next_b;
    end
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// tb/tb_reg_file_bank.sv - scoreboard testbench for reg_file_bank
module tb_reg_file_bank;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int BE_W   = 2;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_RDA  = 0;
  localparam int K_RDB  = 1;
  localparam int K_ENT  = 2;
  localparam int K_RDY  = 3;
  localparam int K_BUSY = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [AW-1:0]           wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [BE_W-1:0]         wr_be;
  logic [AW-1:0]           rd_addr_a;
  logic [AW-1:0]           rd_addr_b;
  logic [DATA_W-1:0]       rd_data_a;
  logic [DATA_W-1:0]       rd_data_b;
  logic                    clear_req;
  logic                    clear_busy;
  logic [DEPTH*DATA_W-1:0] all_regs;

  reg_file_bank #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .all_regs  (all_regs)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                due;
    int                kind;
    int                idx;
    logic [DATA_W-1:0] exp;
    string             name;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int dly, input int kind, input int idx,
                      input logic [DATA_W-1:0] exp, input string name);
    exp_t e;
    e.due  = cyc + dly;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic push_ent(input int dly, input int k, input logic [DATA_W-1:0] exp,
                          input string tag);
    push(dly, K_ENT, k, exp, $sformatf("%s_entry%0d", tag, k));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [BE_W-1:0] be);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    tick();
    wr_valid = 1'b0;
  endtask

  // Monitor: samples on the falling edge, pops every due expectation.
  always @(negedge clk) begin
    logic [DATA_W-1:0] got;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due <= cyc) begin
        case (sbq[i].kind)
          K_RDA:   got = rd_data_a;
          K_RDB:   got = rd_data_b;
          K_ENT:   got = all_regs[sbq[i].idx*DATA_W +: DATA_W];
          K_RDY:   got = DATA_W'(wr_ready);
          default: got = DATA_W'(clear_busy);
        endcase
        vectors++;
        if (sbq[i].due != cyc) begin
          miscompares++;
          $display("FAIL %s: check due at cycle %0d missed (now %0d)", sbq[i].name, sbq[i].due, cyc);
        end else if (got !== sbq[i].exp) begin
          miscompares++;
          $display("FAIL %s (cycle %0d): got %h, expected %h", sbq[i].name, cyc, got, sbq[i].exp);
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_be     = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    clear_req = 1'b0;

    // Reset state
    tick();
    for (int k = 0; k < DEPTH; k++) push_ent(0, k, 16'h0000, "rst");
    push(0, K_RDA, 0, 16'h0000, "rst_rd_a");
    push(0, K_RDB, 0, 16'h0000, "rst_rd_b");
    push(0, K_RDY, 0, 16'h0001, "rst_wr_ready");
    push(0, K_BUSY, 0, 16'h0000, "rst_clear_busy");
    tick();
    reset = 1'b1;
    tick();

    // Byte-masked writes
    do_write(3'd3, 16'hABCD, 2'b11);
    push_ent(0, 3, 16'hABCD, "bm_full");
    do_write(3'd3, 16'h1234, 2'b01);
    push_ent(0, 3, 16'hAB34, "bm_low");
    rd_addr_a = 3'd3;
    tick();
    push(0, K_RDA, 0, 16'hAB34, "bm_rd_a");
    do_write(3'd3, 16'hFFFF, 2'b00);
    push_ent(0, 3, 16'hAB34, "bm_be0");

    // Same-edge write and read
    do_write(3'd2, 16'h0011, 2'b11);
    rd_addr_a = 3'd2;
    rd_addr_b = 3'd2;
    do_write(3'd2, 16'h005A, 2'b11);
    push(0, K_RDA, 0, BYP ? 16'h005A : 16'h0011, "fwd_rd_a");
    push(0, K_RDB, 0, BYP ? 16'h005A : 16'h0011, "fwd_rd_b");
    push_ent(0, 2, 16'h005A, "fwd");
    tick();
    push(0, K_RDA, 0, 16'h005A, "fwd_next_rd_a");
    push(0, K_RDB, 0, 16'h005A, "fwd_next_rd_b");
    do_write(3'd2, 16'h7788, 2'b10);
    push(0, K_RDA, 0, BYP ? 16'h775A : 16'h005A, "fwd_merge_rd_a");
    push_ent(0, 2, 16'h775A, "fwd_merge");
    tick();
    push(0, K_RDA, 0, 16'h775A, "fwd_merge_next_rd_a");

    // Clear sweep with a re-pulse mid-sweep
    for (int k = 0; k < DEPTH; k++) do_write(AW'(k), 16'h00FF, 2'b11);
    rd_addr_a = 3'd7;
    rd_addr_b = 3'd0;
    clear_req = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      push(j, K_BUSY, 0, (j <= 8) ? 16'h0001 : 16'h0000, $sformatf("clr_busy_j%0d", j));
      push(j, K_RDY, 0, (j <= 8) ? 16'h0000 : 16'h0001, $sformatf("clr_ready_j%0d", j));
      for (int k = 0; k < DEPTH; k++)
        push_ent(j, k, (j >= 2 + k) ? 16'h0000 : 16'h00FF, $sformatf("clr_j%0d", j));
    end
    push(1, K_RDB, 0, 16'h00FF, "clr_rd_b_j1");
    push(2, K_RDB, 0, BYP ? 16'h0000 : 16'h00FF, "clr_rd_b_j2");
    push(3, K_RDB, 0, 16'h0000, "clr_rd_b_j3");
    push(9, K_RDA, 0, BYP ? 16'h0000 : 16'h00FF, "clr_rd_a_j9");
    push(10, K_RDA, 0, 16'h0000, "clr_rd_a_j10");
    tick();
    clear_req = 1'b0;
    tick();
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (6) tick();

    // Write and clear_req in the same cycle; write held through the sweep
    wr_valid  = 1'b1;
    wr_addr   = 3'd5;
    wr_data   = 16'h0077;
    wr_be     = 2'b11;
    clear_req = 1'b1;
    push_ent(1, 5, 16'h0077, "wc_j1");
    push(1, K_BUSY, 0, 16'h0001, "wc_busy_j1");
    push(1, K_RDY, 0, 16'h0000, "wc_ready_j1");
    push_ent(5, 6, 16'h0000, "wc_held_j5");
    push_ent(6, 5, 16'h0077, "wc_j6");
    push_ent(7, 5, 16'h0000, "wc_j7");
    push(9, K_BUSY, 0, 16'h0000, "wc_busy_j9");
    push(9, K_RDY, 0, 16'h0001, "wc_ready_j9");
    push_ent(9, 6, 16'h0000, "wc_held_j9");
    push_ent(10, 6, 16'h0066, "wc_held_j10");
    tick();
    clear_req = 1'b0;
    wr_addr   = 3'd6;
    wr_data   = 16'h0066;
    repeat (9) tick();
    wr_valid = 1'b0;

    // Reset in the middle of a sweep, then a full sweep
    for (int k = 0; k < DEPTH; k++) do_write(AW'(k), 16'h003C, 2'b11);
    rd_addr_a = 3'd4;
    rd_addr_b = 3'd6;
    tick();
    push(0, K_RDA, 0, 16'h003C, "mr_pre_rd_a");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++) push_ent(0, k, 16'h0000, "mr");
    push(0, K_RDA, 0, 16'h0000, "mr_rd_a");
    push(0, K_RDB, 0, 16'h0000, "mr_rd_b");
    push(0, K_RDY, 0, 16'h0001, "mr_wr_ready");
    push(0, K_BUSY, 0, 16'h0000, "mr_clear_busy");
    tick();
    reset = 1'b1;
    tick();
    push(0, K_BUSY, 0, 16'h0000, "mr_after_busy");
    do_write(3'd7, 16'h0055, 2'b11);
    clear_req = 1'b1;
    for (int j = 1; j <= 9; j++)
      push(j, K_BUSY, 0, (j <= 8) ? 16'h0001 : 16'h0000, $sformatf("mr_sweep_busy_j%0d", j));
    push_ent(8, 7, 16'h0055, "mr_sweep_j8");
    push_ent(9, 7, 16'h0000, "mr_sweep_j9");
    tick();
    clear_req = 1'b0;
    repeat (10) tick();

    repeat (3) tick();
    while (sbq.size() > 0) begin
      miscompares++;
      $display("FAIL %s: expectation never checked (due %0d)", sbq[0].name, sbq[0].due);
      void'(sbq.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
